alu_seq: RTL and testbench

//   Registered, handshaked ALU for the datapath, replacing the purely combinational ALU.
//   - Parametrised width.
//   - Latches operands on acceptance, so the datapath may change inputs afterwards.
//   - Adds an iterative shift-add multiply (kMUL) and Zero/Carry/Illegal status.
//   - Sits between the register-file read stage and writeback; the control FSM drives InValid and consumes OutValid.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_mul_iter.sv | 51 +++++
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode mnemonics and FSM states.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        kADD = 4'd0,
        kSUB = 4'd1,
        kORR = 4'd2,
        kAND = 4'd3,
        kXOR = 4'd4,
        kXXR = 4'd5,
        kBEQ = 4'd6,
        kBNE = 4'd7,
        kSLL = 4'd8,
        kSRL = 4'd9,
        kMUL = 4'd10
    } op_mne;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } alu_state_t;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
module alu_seq_mul_iter #(
    parameter int W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, acc_d, mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // done fires during the final iteration; prod_o already includes it
    assign done_o = busy_q && (cnt_q == CW'(W - 1));
    assign prod_o = acc_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1))
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with iterative multiply and status flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    output logic           InReady,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic [OPW-1:0] OP,
    output logic           OutValid,
    input  logic           OutReady,
    output logic [W-1:0]   Out,
    output logic [W-1:0]   OutHi,
    output logic           Jump,
    output logic           Zero,
    output logic           Carry,
    output logic           Illegal
);
    localparam logic [W-1:0] WLIM = W'(W);

    alu_state_t     state_q;
    logic [W-1:0]   out_q, hi_q, res_d;
    logic           jump_q, zero_q, carry_q, ill_q;
    logic           carry_d, ill_d, jump_d;
    logic [W:0]     sum, diff;
    logic           accept, is_mul, mul_done;
    logic [2*W-1:0] prod;

    assign InReady = !Reset &&
        (state_q == S_IDLE || (state_q == S_DONE && OutReady));
    assign accept  = InValid && InReady;
    assign is_mul  = (OP == kMUL);

    assign sum  = {1'b0, InputA} + {1'b0, InputB};
    assign diff = {1'b0, InputA} - {1'b0, InputB};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ill_d   = 1'b0;
        case (OP)
            kADD: begin res_d = sum[W-1:0];  carry_d = sum[W];   end
            kSUB: begin res_d = diff[W-1:0]; carry_d = !diff[W]; end
            kORR: res_d = InputA | InputB;
            kAND: res_d = InputA & InputB;
            kXOR: res_d = {{(W-1){1'b0}}, ^InputB};
            kXXR: res_d = {{(W-1){1'b0}}, ^{InputA, InputB}};
            kBEQ: res_d = {{(W-1){1'b0}}, InputA == InputB};
            kBNE: res_d = {{(W-1){1'b0}}, InputA != InputB};
            kSLL: res_d = (InputB >= WLIM) ? '0 : InputA << InputB;
            kSRL: res_d = (InputB >= WLIM) ? '0 : InputA >> InputB;
            kMUL: res_d = '0;
            default: ill_d = 1'b1;
        endcase
        jump_d = (OP == kBEQ || OP == kBNE) && res_d[0];
    end

    alu_seq_mul_iter #(.W(W)) u_mul (
        .Clk     (Clk),
        .Reset   (Reset),
        .start_i (accept && is_mul),
        .a_i     (InputA),
        .b_i     (InputB),
        .done_o  (mul_done),
        .prod_o  (prod)
    );

    // A new accept out of S_DONE overrides the plain return to idle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            jump_q  <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                state_q <= S_BUSY;
            end else begin
                state_q <= S_DONE;
                out_q   <= res_d;
                hi_q    <= '0;
                jump_q  <= jump_d;
                zero_q  <= (res_d == '0);
                carry_q <= carry_d;
                ill_q   <= ill_d;
            end
        end else begin
            unique case (state_q)
                S_BUSY: if (mul_done) begin
                    state_q <= S_DONE;
                    out_q   <= prod[W-1:0];
                    hi_q    <= prod[2*W-1:W];
                    jump_q  <= 1'b0;
                    zero_q  <= (prod[W-1:0] == '0);
                    carry_q <= 1'b0;
                    ill_q   <= 1'b0;
                end
                S_DONE: if (OutReady) state_q <= S_IDLE;
                default: ;
            endcase
        end
    end

    assign OutValid = (state_q == S_DONE);
    assign Out      = out_q;
    assign OutHi    = hi_q;
    assign Jump     = jump_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (W=8).
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       Clk, Reset, InValid, InReady, OutValid, OutReady;
    logic [7:0] InputA, InputB, Out, OutHi;
    logic [3:0] OP;
    logic       Jump, Zero, Carry, Illegal;

    int checks = 0;
    int errors = 0;

    alu_seq #(.W(8), .OPW(4)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InputA(InputA), .InputB(InputB), .OP(OP), .OutValid(OutValid),
        .OutReady(OutReady), .Out(Out), .OutHi(OutHi), .Jump(Jump),
        .Zero(Zero), .Carry(Carry), .Illegal(Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, out, hi;
        logic       j, z, c, il;
        int         lat;
    } vec_t;

    vec_t v[19];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, " OutValid"}, OutValid, 0);
        chk({nm, " InReady"}, InReady, 0);
        chk({nm, " Out"}, Out, 0);
        chk({nm, " OutHi"}, OutHi, 0);
        chk({nm, " flags"}, {Jump, Zero, Carry, Illegal}, 0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        //        op    a      b      out    hi    j  z  c  il lat
        v[0]  = '{kADD, 8'd200,8'd100,8'd44, 8'h0,0, 0, 1, 0, 1};
        v[1]  = '{kSUB, 8'd5,  8'd7,  8'd254,8'h0,0, 0, 0, 0, 1};
        v[2]  = '{kSUB, 8'd9,  8'd9,  8'd0,  8'h0,0, 1, 1, 0, 1};
        v[3]  = '{kORR, 8'hA0, 8'h05, 8'hA5, 8'h0,0, 0, 0, 0, 1};
        v[4]  = '{kAND, 8'hF0, 8'h3C, 8'h30, 8'h0,0, 0, 0, 0, 1};
        v[5]  = '{kXOR, 8'h55, 8'h07, 8'h01, 8'h0,0, 0, 0, 0, 1};
        v[6]  = '{kXXR, 8'h01, 8'h03, 8'h01, 8'h0,0, 0, 0, 0, 1};
        v[7]  = '{kXXR, 8'h03, 8'h00, 8'h00, 8'h0,0, 1, 0, 0, 1};
        v[8]  = '{kBEQ, 8'd7,  8'd7,  8'd1,  8'h0,1, 0, 0, 0, 1};
        v[9]  = '{kBNE, 8'd7,  8'd7,  8'd0,  8'h0,0, 1, 0, 0, 1};
        v[10] = '{kBNE, 8'd3,  8'd4,  8'd1,  8'h0,1, 0, 0, 0, 1};
        v[11] = '{kSLL, 8'd1,  8'd9,  8'd0,  8'h0,0, 1, 0, 0, 1};
        v[12] = '{kSLL, 8'h81, 8'd1,  8'h02, 8'h0,0, 0, 0, 0, 1};
        v[13] = '{kSRL, 8'h80, 8'd7,  8'h01, 8'h0,0, 0, 0, 0, 1};
        v[14] = '{kSRL, 8'hFF, 8'd8,  8'h00, 8'h0,0, 1, 0, 0, 1};
        v[15] = '{kMUL, 8'd13, 8'd11, 8'd143,8'h0,0, 0, 0, 0, 9};
        v[16] = '{kMUL, 8'd255,8'd255,8'h01, 8'hFE,0,0, 0, 0, 9};
        v[17] = '{4'hF, 8'd5,  8'd6,  8'h00, 8'h0,0, 1, 0, 1, 1};
        v[18] = '{kADD, 8'd255,8'd1,  8'h00, 8'h0,0, 1, 1, 0, 1};

        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        InputA = '0; InputB = '0; OP = '0;
        #3;
        chk_zero_outs("reset");
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("post-reset InReady", InReady, 1);
        chk("post-reset OutValid", OutValid, 0);

        OutReady = 1'b1;
        foreach (v[i]) begin
            @(negedge Clk);
            InValid = 1'b1;
            InputA = v[i].a; InputB = v[i].b; OP = v[i].op;
            #1;
            chk($sformatf("v%0d InReady", i), InReady, 1);
            @(posedge Clk);
            #1;
            InValid = 1'b0;
            InputA = ~InputA; InputB = 8'h00; OP = kSUB;
            lat = 1;
            while (!OutValid && lat < 20) begin
                @(posedge Clk);
                #1;
                lat++;
            end
            chk($sformatf("v%0d latency", i), lat, v[i].lat);
            chk($sformatf("v%0d Out", i), Out, v[i].out);
            chk($sformatf("v%0d OutHi", i), OutHi, v[i].hi);
            chk($sformatf("v%0d Jump", i), Jump, v[i].j);
            chk($sformatf("v%0d Zero", i), Zero, v[i].z);
            chk($sformatf("v%0d Carry", i), Carry, v[i].c);
            chk($sformatf("v%0d Illegal", i), Illegal, v[i].il);
        end

        // request held during S_BUSY must be ignored
        @(negedge Clk);
        InValid = 1'b1; InputA = 8'd3; InputB = 8'd5; OP = kMUL;
        @(posedge Clk);
        #1;
        lat = 1;
        while (!OutValid && lat < 20) begin
            InValid = (lat >= 2 && lat <= 4);
            if (InValid) begin
                InputA = 8'd1; InputB = 8'd1; OP = kADD;
            end
            #1;
            if (lat == 3) chk("busy InReady", InReady, 0);
            @(posedge Clk);
            #1;
            lat++;
        end
        InValid = 1'b0;
        chk("busy mul latency", lat, 9);
        chk("busy mul Out", Out, 15);

        // output hold under backpressure, then back-to-back accept
        @(posedge Clk);
        #1;
        @(negedge Clk);
        InValid = 1'b1; InputA = 8'd1; InputB = 8'd1; OP = kADD;
        OutReady = 1'b0;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk($sformatf("hold%0d OutValid", k), OutValid, 1);
            chk($sformatf("hold%0d Out", k), Out, 2);
            chk($sformatf("hold%0d InReady", k), InReady, 0);
        end
        OutReady = 1'b1; InValid = 1'b1;
        InputA = 8'hF0; InputB = 8'h3C; OP = kAND;
        #1;
        chk("b2b InReady", InReady, 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        chk("b2b OutValid", OutValid, 1);
        chk("b2b Out", Out, 8'h30);
        @(posedge Clk);
        #1;
        chk("b2b idle OutValid", OutValid, 0);

        // reset in the 4th S_BUSY cycle of a multiply
        @(negedge Clk);
        InValid = 1'b1; InputA = 8'd7; InputB = 8'd7; OP = kMUL;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk_zero_outs("midmul reset");
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("midmul InReady", InReady, 1);
        seen = 1'b0;
        repeat (15) begin
            @(posedge Clk);
            #1;
            if (OutValid) seen = 1'b1;
        end
        chk("midmul no OutValid", seen, 0);

        @(negedge Clk);
        InValid = 1'b1; InputA = 8'd2; InputB = 8'd3; OP = kADD;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        chk("after reset OutValid", OutValid, 1);
        chk("after reset Out", Out, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
